// File: rtl/alu_arbiter_if.sv
// Request/response bus for alu_arbiter.
//   req_valid[1:0]  per-requester request strobe
//   req_ready[1:0]  per-requester accept (one-hot grant or zero)
//   req_a/req_b     packed operands {req1[15:0], req0[15:0]}
//   req_op          packed opcodes  {req1[7:0],  req0[7:0]}
//   rsp_valid/rsp_ready  response handshake
//   rsp_id          requester the response belongs to
//   rsp_result/rsp_flags captured ALU result and flags {N,Z,F,L,C}
// master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [15:0] req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic [4:0]  rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// A granted request's operands are driven onto alu_* for ALU_LAT cycles,
// the ALU result/flags are captured and presented as a response held until
// the consumer accepts it.
//   clk, reset_n          clock, synchronous active-low reset
//   bus (slave)           request/response handshake bus
//   alu_a/alu_b/alu_opcode  registered ALU operand drive
//   alu_result/alu_flags  ALU combinational result, flags {N,Z,F,L,C}
//   busy                  high whenever the FSM is not IDLE
//   done_count            completed responses, wraps at 16 bits
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1  // 1..15
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_arbiter_if.slave  bus,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  output logic [7:0]    alu_opcode,
  input  logic [15:0]   alu_result,
  input  logic [4:0]    alu_flags,
  output logic          busy,
  output logic [15:0]   done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic       prio;
  logic [3:0] cnt;
  logic [1:0] grant;

  // Grant is combinational so a request can be accepted in the same cycle
  // it is presented; held at zero during reset and outside IDLE.
  always_comb begin
    grant = '0;
    if (reset_n && state == IDLE) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
    bus.req_ready = grant;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      prio           <= 1'b0;
      cnt            <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_opcode     <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      busy           <= 1'b0;
      done_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            alu_a      <= grant[1] ? bus.req_a[31:16]  : bus.req_a[15:0];
            alu_b      <= grant[1] ? bus.req_b[31:16]  : bus.req_b[15:0];
            alu_opcode <= grant[1] ? bus.req_op[15:8]  : bus.req_op[7:0];
            bus.rsp_id <= grant[1];
            cnt        <= 4'(ALU_LAT);
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt - 4'd1;
          // Capture on the last EXEC cycle so EXEC spans exactly ALU_LAT cycles.
          if (cnt == 4'd1) begin
            bus.rsp_result <= alu_result;
            bus.rsp_flags  <= alu_flags;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            prio          <= ~bus.rsp_id;
            done_count    <= done_count + 16'd1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_XOR = 8'h03;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if if1 ();
  alu_arbiter_if if4 ();

  logic [15:0] alu_a1, alu_b1, alu_res1, done1;
  logic [7:0]  alu_op1;
  logic [4:0]  alu_flg1;
  logic        busy1;
  logic [15:0] alu_a4, alu_b4, alu_res4, done4;
  logic [7:0]  alu_op4;
  logic [4:0]  alu_flg4;
  logic        busy4;

  // Reference ALU: flags {N,Z,F,L,C}
  function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [7:0] op);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    logic        f;
    s = '0;
    r = '0;
    c = 1'b0;
    f = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        f = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return {r[15], (r == 16'h0000), f, (a < b), c, r};
  endfunction

  assign {alu_flg1, alu_res1} = alu_fn(alu_a1, alu_b1, alu_op1);
  assign {alu_flg4, alu_res4} = alu_fn(alu_a4, alu_b4, alu_op4);

  alu_arbiter dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_op1),
    .alu_result(alu_res1), .alu_flags(alu_flg1),
    .busy(busy1), .done_count(done1)
  );

  alu_arbiter #(.ALU_LAT(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(if4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_opcode(alu_op4),
    .alu_result(alu_res4), .alu_flags(alu_flg4),
    .busy(busy4), .done_count(done4)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    reset_n = 1'b0;
    if1.req_valid = 2'b01;
    if4.req_valid = 2'b10;
    repeat (2) @(negedge clk);
    checks++;
    if ({if1.req_ready, if4.req_ready} !== 4'b0000)
      $display("FAIL reset_req_ready: got %b/%b want 00/00", if1.req_ready, if4.req_ready);
    else passes++;
    checks++;
    if ({busy1, if1.rsp_valid, if1.rsp_id, done1} !== 19'd0)
      $display("FAIL reset_ctrl: busy=%b rsp_valid=%b rsp_id=%b done=%h want all 0",
               busy1, if1.rsp_valid, if1.rsp_id, done1);
    else passes++;
    checks++;
    if ({alu_a1, alu_b1, alu_op1, if1.rsp_result, if1.rsp_flags} !== 61'd0)
      $display("FAIL reset_data: a=%h b=%h op=%h res=%h flg=%b want 0",
               alu_a1, alu_b1, alu_op1, if1.rsp_result, if1.rsp_flags);
    else passes++;
    if1.req_valid = 2'b00;
    if4.req_valid = 2'b00;
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    if1.req_a = {16'h0000, 16'hCAFE};
    if1.req_b = {16'h0000, 16'h1234};
    if1.req_op = {8'h00, OP_ADD};
    if1.rsp_ready = 1'b1;
    if1.req_valid = 2'b01;
    #1;
    checks++;
    if (if1.req_ready !== 2'b01)
      $display("FAIL single_grant: got %b want 01", if1.req_ready);
    else passes++;
    @(negedge clk);
    if1.req_valid = 2'b00;
    checks++;
    if ({busy1, if1.rsp_valid, alu_a1, alu_b1, alu_op1} !== {1'b1, 1'b0, 16'hCAFE, 16'h1234, OP_ADD})
      $display("FAIL single_exec: busy=%b rv=%b a=%h b=%h op=%h want 1 0 cafe 1234 01",
               busy1, if1.rsp_valid, alu_a1, alu_b1, alu_op1);
    else passes++;
    @(negedge clk);
    checks++;
    if ({if1.rsp_valid, if1.rsp_result, if1.rsp_flags, if1.rsp_id} !== {1'b1, 16'hDD32, 5'b10000, 1'b0})
      $display("FAIL single_rsp: rv=%b res=%h flg=%b id=%b want 1 dd32 10000 0",
               if1.rsp_valid, if1.rsp_result, if1.rsp_flags, if1.rsp_id);
    else passes++;
    @(negedge clk);
    checks++;
    if ({if1.rsp_valid, busy1, done1} !== {1'b0, 1'b0, 16'd1})
      $display("FAIL single_done: rv=%b busy=%b done=%0d want 0 0 1", if1.rsp_valid, busy1, done1);
    else passes++;
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g;
    logic [15:0] exp_r;
    int          last_acc;
    int          t;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    if1.req_a = {16'h0010, 16'h0001};
    if1.req_b = {16'h0020, 16'h0002};
    if1.req_op = {OP_ADD, OP_ADD};
    if1.rsp_ready = 1'b1;
    if1.req_valid = 2'b11;
    last_acc = 0;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_r = (i % 2 == 1) ? 16'h0030 : 16'h0003;
      #1;
      t = 0;
      while (if1.req_ready == 2'b00 && t < 10) begin
        @(negedge clk);
        #1;
        t++;
      end
      checks++;
      if (if1.req_ready !== exp_g)
        $display("FAIL contention_grant[%0d]: got %b want %b", i, if1.req_ready, exp_g);
      else passes++;
      if (i > 0) begin
        checks++;
        if (cyc - last_acc !== 3)
          $display("FAIL contention_spacing[%0d]: got %0d want 3", i, cyc - last_acc);
        else passes++;
      end
      last_acc = cyc;
      @(negedge clk);
      t = 0;
      while (!if1.rsp_valid && t < 10) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if ({if1.rsp_valid, if1.rsp_id, if1.rsp_result} !== {1'b1, exp_g[1], exp_r})
        $display("FAIL contention_rsp[%0d]: rv=%b id=%b res=%h want 1 %b %h",
                 i, if1.rsp_valid, if1.rsp_id, if1.rsp_result, exp_g[1], exp_r);
      else passes++;
      @(negedge clk);
    end
    if1.req_valid = 2'b00;
    checks++;
    if (done1 !== 16'd4)
      $display("FAIL contention_done: got %0d want 4", done1);
    else passes++;
  endtask

  task automatic test_backpressure();
    int t;
    if1.req_a = {16'h0000, 16'hAAAA};
    if1.req_b = {16'h0000, 16'h5555};
    if1.req_op = {OP_ADD, OP_XOR};
    if1.rsp_ready = 1'b0;
    if1.req_valid = 2'b01;
    @(negedge clk);
    if1.req_valid = 2'b11;
    t = 0;
    while (!if1.rsp_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({if1.rsp_valid, if1.rsp_result, if1.rsp_flags, if1.rsp_id, if1.req_ready, busy1} !==
          {1'b1, 16'hFFFF, 5'b10000, 1'b0, 2'b00, 1'b1})
        $display("FAIL backpressure_hold[%0d]: rv=%b res=%h flg=%b id=%b rdy=%b busy=%b want 1 ffff 10000 0 00 1",
                 i, if1.rsp_valid, if1.rsp_result, if1.rsp_flags, if1.rsp_id, if1.req_ready, busy1);
      else passes++;
      @(negedge clk);
    end
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({if1.rsp_valid, busy1, if1.req_ready, done1} !== {1'b0, 1'b0, 2'b10, 16'd5})
      $display("FAIL backpressure_release: rv=%b busy=%b rdy=%b done=%0d want 0 0 10 5",
               if1.rsp_valid, busy1, if1.req_ready, done1);
    else passes++;
    if1.req_valid = 2'b00;
  endtask

  task automatic test_latency();
    if4.req_a = {16'hFF00, 16'h0000};
    if4.req_b = {16'h00FF, 16'h0000};
    if4.req_op = {OP_AND, 8'h00};
    if4.rsp_ready = 1'b1;
    if4.req_valid = 2'b10;
    #1;
    checks++;
    if (if4.req_ready !== 2'b10)
      $display("FAIL latency_grant: got %b want 10", if4.req_ready);
    else passes++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if4.req_valid = 2'b00;
      checks++;
      if ({alu_a4, alu_b4, alu_op4, if4.rsp_valid} !== {16'hFF00, 16'h00FF, OP_AND, 1'b0})
        $display("FAIL latency_exec[%0d]: a=%h b=%h op=%h rv=%b want ff00 00ff 02 0",
                 k, alu_a4, alu_b4, alu_op4, if4.rsp_valid);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if ({if4.rsp_valid, if4.rsp_result, if4.rsp_flags[3], if4.rsp_flags, if4.rsp_id} !==
        {1'b1, 16'h0000, 1'b1, 5'b01000, 1'b1})
      $display("FAIL latency_rsp: rv=%b res=%h flg=%b id=%b want 1 0000 01000 1",
               if4.rsp_valid, if4.rsp_result, if4.rsp_flags, if4.rsp_id);
    else passes++;
    @(negedge clk);
    checks++;
    if ({done4, busy4} !== {16'd1, 1'b0})
      $display("FAIL latency_done: done=%0d busy=%b want 1 0", done4, busy4);
    else passes++;
  endtask

  task automatic test_reset_midop();
    if1.req_a = {16'h0010, 16'h0001};
    if1.req_b = {16'h0020, 16'h0002};
    if1.req_op = {OP_ADD, OP_ADD};
    if1.rsp_ready = 1'b1;
    if1.req_valid = 2'b01;
    @(negedge clk);
    reset_n = 1'b0;
    if1.req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if ({busy1, if1.rsp_valid, done1, if1.req_ready} !== {1'b0, 1'b0, 16'd0, 2'b00})
      $display("FAIL midop_reset: busy=%b rv=%b done=%0d rdy=%b want 0 0 0 00",
               busy1, if1.rsp_valid, done1, if1.req_ready);
    else passes++;
    reset_n = 1'b1;
    #1;
    checks++;
    if (if1.req_ready !== 2'b01)
      $display("FAIL midop_first_grant: got %b want 01", if1.req_ready);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({if1.rsp_valid, if1.rsp_id, if1.rsp_result} !== {1'b1, 1'b0, 16'h0003})
      $display("FAIL midop_rsp0: rv=%b id=%b res=%h want 1 0 0003",
               if1.rsp_valid, if1.rsp_id, if1.rsp_result);
    else passes++;
    @(negedge clk);
    #1;
    checks++;
    if (if1.req_ready !== 2'b10)
      $display("FAIL midop_second_grant: got %b want 10", if1.req_ready);
    else passes++;
    @(negedge clk);
    if1.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({if1.rsp_valid, if1.rsp_id, if1.rsp_result} !== {1'b1, 1'b1, 16'h0030})
      $display("FAIL midop_rsp1: rv=%b id=%b res=%h want 1 1 0030",
               if1.rsp_valid, if1.rsp_id, if1.rsp_result);
    else passes++;
    @(negedge clk);
    checks++;
    if (done1 !== 16'd2)
      $display("FAIL midop_done: got %0d want 2", done1);
    else passes++;
  endtask

  task automatic test_wrap();
    force dut1.done_count = 16'hFFFF;
    #1;
    release dut1.done_count;
    #1;
    if1.req_a = {16'h0000, 16'h0005};
    if1.req_b = {16'h0000, 16'h0006};
    if1.req_op = {8'h00, OP_ADD};
    if1.rsp_ready = 1'b1;
    if1.req_valid = 2'b01;
    @(negedge clk);
    if1.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({if1.rsp_valid, if1.rsp_result} !== {1'b1, 16'h000B})
      $display("FAIL wrap_rsp: rv=%b res=%h want 1 000b", if1.rsp_valid, if1.rsp_result);
    else passes++;
    @(negedge clk);
    checks++;
    if (done1 !== 16'h0000)
      $display("FAIL wrap_done: got %h want 0000", done1);
    else passes++;
  endtask

  initial begin
    reset_n = 1'b0;
    if1.req_valid = '0; if1.req_a = '0; if1.req_b = '0; if1.req_op = '0; if1.rsp_ready = 1'b0;
    if4.req_valid = '0; if4.req_a = '0; if4.req_b = '0; if4.req_op = '0; if4.rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_latency();
    test_reset_midop();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LAT, default 1, sets the number of cycles operands are held on the ALU before capture (legal 1..15).
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  2  per-requester request strobe (bit i = requester i).
REQ-005 req_ready  output  2  per-requester accept; request i is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-006 req_a  input  32  packed operand A: {req1_a[15:0], req0_a[15:0]}.
REQ-007 req_b  input  32  packed operand B: {req1_b, req0_b}.
REQ-008 req_op  input  16  packed opcode: {req1_op[7:0], req0_op[7:0]}.
REQ-009 alu_a, alu_b  output  16 each  ALU operand drive.
REQ-010 alu_opcode  output  8  ALU opcode drive.
REQ-011 alu_result  input  16  ALU combinational result.
REQ-012 alu_flags  input  5  ALU flags {N,Z,F,L,C} (bit0 = C).
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumer accept.
REQ-015 rsp_id  output  1  requester index the response belongs to.
REQ-016 rsp_result  output  16  captured result; rsp_flags  output  5  captured flags.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done_count  output  16  count of completed responses.

Function
REQ-019 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-020 In IDLE, req_ready SHALL be a one-hot grant, or zero; it is combinational from req_valid and prio. All other outputs SHALL be registered.
REQ-021 Grant rule: one valid requester → grant it; both valid → grant requester prio; none valid → req_ready=0 and the FSM stays in IDLE.
REQ-022 On accept, the block SHALL latch req_a/req_b/req_op slice g into alu_a/alu_b/alu_opcode and g into rsp_id, load the wait counter with ALU_LAT, and go to EXEC.
REQ-023 In EXEC, alu_a/alu_b/alu_opcode SHALL hold stable and the counter SHALL decrement each cycle.
REQ-024 When the counter reaches 1 in EXEC, the block SHALL capture alu_result/alu_flags into rsp_result/rsp_flags and go to RESP; EXEC therefore lasts exactly ALU_LAT cycles.
REQ-025 In RESP, rsp_valid SHALL be 1 and rsp_result/rsp_flags/rsp_id SHALL hold stable until rsp_valid && rsp_ready.
REQ-026 On that handshake the FSM SHALL go to IDLE, set prio to ~rsp_id (round-robin), and increment done_count.
REQ-027 done_count SHALL wrap from 16'hFFFF to 0.
REQ-028 req_ready SHALL be 0 in EXEC and RESP; req_valid changes in those states SHALL have no effect.
REQ-029 rsp_ready asserted outside RESP SHALL be ignored.
REQ-030 Minimum accept-to-accept spacing SHALL be ALU_LAT+2 cycles (1 IDLE + ALU_LAT EXEC + 1 RESP, with rsp_ready held high).
REQ-031 alu_a/alu_b/alu_opcode SHALL retain their last values in IDLE and RESP.

Reset
REQ-032 reset_n=0 at a clock edge SHALL force, from any state including mid-EXEC or RESP: state=IDLE, prio=0, counter=0, alu_a=alu_b=0, alu_opcode=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, done_count=0, busy=0.
REQ-033 Any request in flight when reset asserts SHALL be discarded with no response, and req_ready SHALL be 0 while reset_n=0.

Verification
REQ-034 Single op: req0 valid, a=16'hCAFE, b=16'h1234, ADD; ALU_LAT=1; rsp_ready=1. Required: req_ready=2'b01 in cycle 0; rsp_valid in cycle 2 with rsp_result=16'hDD32, C=0, rsp_id=0; done_count=1.
REQ-035 Contention: both requesters valid and held after reset. Required: grant order 0,1,0,1 over four ops; rsp_id sequence matches the grants.
REQ-036 Back-pressure: rsp_ready=0 for 5 cycles in RESP. Required: rsp_valid/rsp_result stable throughout, req_ready=0, no new accept until the cycle after the handshake.
REQ-037 Latency: ALU_LAT=4; req1 AND, a=16'hFF00, b=16'h00FF. Required: rsp_valid exactly 5 cycles after accept, rsp_result=0, Z flag=1, operands stable on alu_* for all 4 EXEC cycles.
REQ-038 Reset mid-op: reset_n=0 for one cycle during EXEC. Required: next cycle busy=0, rsp_valid=0, done_count=0, prio=0; a pending req1 and req0 then resolve with req0 granted first.
REQ-039 Wrap: preload 65535 completions (or force done_count=16'hFFFF), complete one op. Required: done_count=0.
